// File: rtl/planes_bus_pkg.sv
// Shared types and constants for the CPU-side initiator toward the tilemap planes block.
package planes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_CAPTURE,
    ST_RELEASE,
    ST_HOLD
  } state_e;

  localparam int         DTACK_SYNC_DEPTH = 2;
  localparam logic [7:0] OPEN_BUS         = 8'hFF;

  // k052109 has priority when both tile chips claim the bus.
  function automatic logic [7:0] pick_rdata(input logic       dir_a,
                                            input logic [7:0] data_a,
                                            input logic       dir_b,
                                            input logic [7:0] data_b);
    if (dir_a)      return data_a;
    else if (dir_b) return data_b;
    else            return OPEN_BUS;
  endfunction

endpackage

// File: rtl/planes_dtack_sync.sv
// Multi-flop synchronizer for the active-low VDTAC acknowledge; presets to idle-high.
module planes_dtack_sync
  import planes_bus_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [DTACK_SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[DTACK_SYNC_DEPTH-2:0], async_i};
  end

  assign sync_o = sync_q[DTACK_SYNC_DEPTH-1];

endmodule

// File: rtl/planes_bus_master.sv
// Converts a req/done handshake into 68000-style strobes toward the planes block,
// waits for VDTAC and captures read data from the driving tile chip.
module planes_bus_master
  import planes_bus_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic        clk_main,
  input  logic        nRES,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic        req_uds,
  input  logic        req_rmrd,
  input  logic [7:0]  req_wdata,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        contention,
  output logic        VRAMCS,
  output logic        PDS,
  output logic        NREAD,
  output logic        nUDS,
  output logic        m68k_addr_16,
  output logic [14:0] AB,
  output logic [7:0]  DB_IN,
  output logic        RMRD,
  input  logic        VDTAC,
  input  logic [7:0]  DB_OUT_k052109,
  input  logic        DBDIR_k052109,
  input  logic [7:0]  DB_OUT_k051962,
  input  logic        DBDIR_k051962
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vramcs_q, vramcs_d;
  logic             pds_q, pds_d;
  logic             nread_q, nread_d;
  logic             nuds_q, nuds_d;
  logic             a16_q, a16_d;
  logic [14:0]      ab_q, ab_d;
  logic [7:0]       db_in_q, db_in_d;
  logic             rmrd_q, rmrd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
  logic             busy_q, busy_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             contention_q, contention_d;
  logic             vdtac_s;

  planes_dtack_sync u_dtack_sync (
    .clk_i   (clk_main),
    .rst_ni  (nRES),
    .async_i (VDTAC),
    .sync_o  (vdtac_s)
  );

  always_ff @(posedge clk_main or negedge nRES) begin
    if (!nRES) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vramcs_q     <= 1'b1;
      pds_q        <= 1'b1;
      nread_q      <= 1'b1;
      nuds_q       <= 1'b1;
      a16_q        <= 1'b0;
      ab_q         <= '0;
      db_in_q      <= '0;
      rmrd_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      rdata_q      <= OPEN_BUS;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vramcs_q     <= vramcs_d;
      pds_q        <= pds_d;
      nread_q      <= nread_d;
      nuds_q       <= nuds_d;
      a16_q        <= a16_d;
      ab_q         <= ab_d;
      db_in_q      <= db_in_d;
      rmrd_q       <= rmrd_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_flag_q   <= err_flag_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
      contention_q <= contention_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vramcs_d     = vramcs_q;
    pds_d        = pds_q;
    nread_d      = nread_q;
    nuds_d       = nuds_q;
    a16_d        = a16_q;
    ab_d         = ab_q;
    db_in_d      = db_in_q;
    rmrd_d       = rmrd_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_flag_d   = err_flag_q;
    busy_d       = busy_q;
    rdata_d      = rdata_q;
    contention_d = contention_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          nread_d    = req_wr;
          nuds_d     = ~req_uds;
          a16_d      = req_addr[15];
          ab_d       = req_addr[14:0];
          rmrd_d     = req_rmrd;
          if (req_wr) db_in_d = req_wdata;
          busy_d     = 1'b1;
          err_flag_d = 1'b0;
          cnt_d      = CNT_W'(SETUP_CYC);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q <= CNT_ONE) begin
          pds_d    = 1'b0;
          vramcs_d = 1'b0;
          state_d  = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        cnt_d   = CNT_W'(TIMEOUT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!vdtac_s) begin
          state_d = ST_CAPTURE;
        end else if (cnt_q <= CNT_ONE) begin
          // Abort without capturing: rdata keeps its previous value.
          err_flag_d = 1'b1;
          pds_d      = 1'b1;
          vramcs_d   = 1'b1;
          cnt_d      = CNT_W'(TIMEOUT);
          state_d    = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (!nread_q) begin
          rdata_d = pick_rdata(DBDIR_k052109, DB_OUT_k052109,
                               DBDIR_k051962, DB_OUT_k051962);
          if (DBDIR_k052109 && DBDIR_k051962) contention_d = 1'b1;
        end
        pds_d    = 1'b1;
        vramcs_d = 1'b1;
        cnt_d    = CNT_W'(TIMEOUT);
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Counter bounds the wait for VDTAC to be withdrawn.
        if (vdtac_s) begin
          cnt_d   = CNT_W'(HOLD_CYC);
          state_d = ST_HOLD;
        end else if (cnt_q <= CNT_ONE) begin
          err_flag_d = 1'b1;
          cnt_d      = CNT_W'(HOLD_CYC);
          state_d    = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          done_d     = 1'b1;
          err_d      = err_flag_q;
          err_flag_d = 1'b0;
          busy_d     = 1'b0;
          nread_d    = 1'b1;
          nuds_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign contention   = contention_q;
  assign VRAMCS       = vramcs_q;
  assign PDS          = pds_q;
  assign NREAD        = nread_q;
  assign nUDS         = nuds_q;
  assign m68k_addr_16 = a16_q;
  assign AB           = ab_q;
  assign DB_IN        = db_in_q;
  assign RMRD         = rmrd_q;

endmodule

// File: tb/tb_planes_bus_master.sv
// Directed bench for planes_bus_master with a small VDTAC responder model.
module tb_planes_bus_master;

  localparam int TIMEOUT   = 8;
  localparam int SETUP_CYC = 1;
  localparam int HOLD_CYC  = 1;

  logic        clk_main;
  logic        nRES;
  logic        req, req_wr, req_uds, req_rmrd;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        done, err, busy, contention;
  logic [7:0]  rdata;
  logic        VRAMCS, PDS, NREAD, nUDS, m68k_addr_16, RMRD;
  logic [14:0] AB;
  logic [7:0]  DB_IN;
  logic        VDTAC;
  logic [7:0]  DB_OUT_k052109, DB_OUT_k051962;
  logic        DBDIR_k052109, DBDIR_k051962;

  planes_bus_master #(
    .TIMEOUT   (TIMEOUT),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk_main       (clk_main),
    .nRES           (nRES),
    .req            (req),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_uds        (req_uds),
    .req_rmrd       (req_rmrd),
    .req_wdata      (req_wdata),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .busy           (busy),
    .contention     (contention),
    .VRAMCS         (VRAMCS),
    .PDS            (PDS),
    .NREAD          (NREAD),
    .nUDS           (nUDS),
    .m68k_addr_16   (m68k_addr_16),
    .AB             (AB),
    .DB_IN          (DB_IN),
    .RMRD           (RMRD),
    .VDTAC          (VDTAC),
    .DB_OUT_k052109 (DB_OUT_k052109),
    .DBDIR_k052109  (DBDIR_k052109),
    .DB_OUT_k051962 (DB_OUT_k051962),
    .DBDIR_k051962  (DBDIR_k051962)
  );

  initial begin
    clk_main = 1'b0;
    forever #5 clk_main = ~clk_main;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Planes block model: acknowledge ack_dly cycles after PDS falls, withdraw after PDS rises.
  logic ack_en;
  int   ack_dly;
  initial begin
    VDTAC = 1'b1;
    forever begin
      @(negedge PDS);
      if (ack_en) begin
        repeat (ack_dly) @(negedge clk_main);
        VDTAC = 1'b0;
        wait (PDS === 1'b1);
        @(negedge clk_main);
        VDTAC = 1'b1;
      end
    end
  end

  int         done_cnt, err_cnt, pds_low, pds_falls, nuds_bad;
  logic       err_at_done, nread_pre, busy_at_done;
  logic [7:0] dbin_pre, rdata_at_done;

  task automatic run_access(input logic wr, input logic [15:0] addr, input logic uds,
                            input logic [7:0] wd, input logic rmrd);
    logic       pds_prev, nread_prev;
    logic [7:0] dbin_prev;
    int         post;
    done_cnt = 0; err_cnt = 0; pds_low = 0; pds_falls = 0; nuds_bad = 0;
    err_at_done = 1'b0; busy_at_done = 1'b1; rdata_at_done = 8'h00;
    nread_pre = 1'bx; dbin_pre = 8'hxx;
    @(negedge clk_main);
    req_wr = wr; req_addr = addr; req_uds = uds; req_wdata = wd; req_rmrd = rmrd;
    req = 1'b1;
    pds_prev = PDS; nread_prev = NREAD; dbin_prev = DB_IN;
    @(negedge clk_main);
    req = 1'b0;
    post = -1;
    for (int i = 0; i < 100 && post != 0; i++) begin
      if (PDS === 1'b0) pds_low++;
      if (pds_prev === 1'b1 && PDS === 1'b0) begin
        pds_falls++;
        nread_pre = nread_prev;
        dbin_pre  = dbin_prev;
      end
      if (busy === 1'b1 && nUDS !== ~uds) nuds_bad++;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        err_at_done   = err;
        rdata_at_done = rdata;
        busy_at_done  = busy;
        post = 3;
      end
      pds_prev = PDS; nread_prev = NREAD; dbin_prev = DB_IN;
      if (post > 0) post--;
      if (post != 0) @(negedge clk_main);
    end
  endtask

  int   b2b_done, b2b_falls, gap, gap_run;
  logic vr_prev, in_gap;
  logic done_in_rst;
  int   wait_cnt;

  initial begin
    nRES = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_uds = 1'b0;
    req_rmrd = 1'b0; req_wdata = '0; ack_en = 1'b0; ack_dly = 3;
    DB_OUT_k052109 = 8'h00; DBDIR_k052109 = 1'b0;
    DB_OUT_k051962 = 8'h00; DBDIR_k051962 = 1'b0;

    repeat (2) @(negedge clk_main);
    check("rst_strobes", {VRAMCS, PDS, NREAD, nUDS}, 4'hF);
    check("rst_bus", {m68k_addr_16, AB, DB_IN, RMRD}, 25'h0);
    check("rst_status", {done, err, busy, contention}, 4'h0);
    check("rst_rdata", rdata, 8'hFF);
    nRES = 1'b1;
    @(negedge clk_main);

    // Timeout with VDTAC never asserted
    ack_en = 1'b0;
    run_access(1'b0, 16'h0C00, 1'b0, 8'h00, 1'b0);
    check("to_done", done_cnt, 1);
    check("to_err_with_done", err_at_done, 1'b1);
    check("to_err_pulses", err_cnt, 1);
    check("to_rdata_kept", rdata_at_done, 8'hFF);
    check("to_strobes_idle", {PDS, VRAMCS}, 2'b11);
    check("to_busy_at_done", busy_at_done, 1'b0);

    // Read from k052109, acknowledge 3 cycles after PDS
    ack_en = 1'b1; ack_dly = 3;
    DBDIR_k052109 = 1'b1; DB_OUT_k052109 = 8'h5A;
    DBDIR_k051962 = 1'b0; DB_OUT_k051962 = 8'h77;
    run_access(1'b0, 16'h0C00, 1'b0, 8'h00, 1'b1);
    check("rd_done", done_cnt, 1);
    check("rd_err", err_cnt, 0);
    check("rd_rdata", rdata_at_done, 8'h5A);
    check("rd_pds_low_ge2", (pds_low >= 2), 1'b1);
    check("rd_nread_pre", nread_pre, 1'b0);
    check("rd_addr", {m68k_addr_16, AB}, 16'h0C00);
    check("rd_rmrd", RMRD, 1'b1);
    check("rd_nread_after", NREAD, 1'b1);
    check("rd_contention", contention, 1'b0);

    // Write with upper-byte select
    DBDIR_k052109 = 1'b0;
    run_access(1'b1, 16'h8123, 1'b1, 8'hA5, 1'b0);
    check("wr_done", done_cnt, 1);
    check("wr_pds_falls", pds_falls, 1);
    check("wr_nread_pre", nread_pre, 1'b1);
    check("wr_dbin_pre", dbin_pre, 8'hA5);
    check("wr_nuds_low", nuds_bad, 0);
    check("wr_rdata_kept", rdata_at_done, 8'h5A);
    check("wr_addr", {m68k_addr_16, AB}, 16'h8123);
    check("wr_nuds_after", nUDS, 1'b1);

    // Read from k051962 only; DB_IN must keep the written byte
    DBDIR_k051962 = 1'b1; DB_OUT_k051962 = 8'h3C;
    run_access(1'b0, 16'h0002, 1'b0, 8'h99, 1'b0);
    check("rd2_rdata", rdata_at_done, 8'h3C);
    check("rd2_dbin_held", DB_IN, 8'hA5);
    check("rd2_contention", contention, 1'b0);

    // Open bus
    DBDIR_k051962 = 1'b0;
    run_access(1'b0, 16'h0004, 1'b0, 8'h00, 1'b0);
    check("open_rdata", rdata_at_done, 8'hFF);

    // Contention
    DBDIR_k052109 = 1'b1; DB_OUT_k052109 = 8'h11;
    DBDIR_k051962 = 1'b1; DB_OUT_k051962 = 8'h22;
    run_access(1'b0, 16'h0006, 1'b0, 8'h00, 1'b0);
    check("cont_rdata", rdata_at_done, 8'h11);
    check("cont_flag", contention, 1'b1);
    DBDIR_k052109 = 1'b0;
    run_access(1'b0, 16'h0008, 1'b0, 8'h00, 1'b0);
    check("cont_rdata2", rdata_at_done, 8'h22);
    check("cont_sticky", contention, 1'b1);

    // Back-to-back with req held high
    ack_dly = 1;
    DBDIR_k052109 = 1'b1; DB_OUT_k052109 = 8'h66; DBDIR_k051962 = 1'b0;
    b2b_done = 0; b2b_falls = 0; gap = 0; gap_run = 0; in_gap = 1'b0;
    @(negedge clk_main);
    req_wr = 1'b0; req_addr = 16'h0010; req_uds = 1'b0; req = 1'b1;
    vr_prev = VRAMCS;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_main);
      if (done === 1'b1) b2b_done++;
      if (vr_prev === 1'b1 && VRAMCS === 1'b0) begin
        b2b_falls++;
        if (in_gap) begin
          gap = gap_run;
          in_gap = 1'b0;
        end
        if (b2b_falls >= 2) req = 1'b0;
      end
      if (vr_prev === 1'b0 && VRAMCS === 1'b1 && b2b_falls == 1) begin
        in_gap = 1'b1;
        gap_run = 0;
      end
      if (in_gap && VRAMCS === 1'b1) gap_run++;
      vr_prev = VRAMCS;
    end
    req = 1'b0;
    check("b2b_done", b2b_done, 2);
    check("b2b_accesses", b2b_falls, 2);
    check("b2b_gap_ge", (gap >= HOLD_CYC + 1), 1'b1);
    check("b2b_rdata", rdata, 8'h66);

    // Reset while waiting for VDTAC
    ack_en = 1'b0;
    @(negedge clk_main);
    req_wr = 1'b0; req_addr = 16'h0020; req = 1'b1;
    @(negedge clk_main);
    req = 1'b0;
    wait_cnt = 0;
    while (PDS !== 1'b0 && wait_cnt < 20) begin
      @(negedge clk_main);
      wait_cnt++;
    end
    check("mid_pds_low", PDS, 1'b0);
    repeat (2) @(negedge clk_main);
    nRES = 1'b0;
    #1;
    check("mid_rst_strobes", {PDS, VRAMCS, busy}, 3'b110);
    done_in_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_main);
      if (i == 3) nRES = 1'b1;
      if (done === 1'b1) done_in_rst = 1'b1;
    end
    check("mid_no_done", done_in_rst, 1'b0);
    check("mid_rdata", rdata, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/planes_bus_master.md
Name: planes_bus_master

Overview:
- CPU-side initiator for the tilemap plane subsystem.
- Converts a simple request/done handshake from a testbench or CPU model into 68000-style strobes toward the planes block: VRAMCS, PDS, NREAD, nUDS, the address bus, and a data byte.
- Waits for that block's active-low VDTAC acknowledge and captures read data from whichever tile chip (k052109 or k051962) is driving the bus.
- Sits between the main CPU bus model and the planes block, in the clk_main domain.

Parameters:
- TIMEOUT, 255: clk_main cycles to wait for VDTAC low before aborting; minimum 4.
- SETUP_CYC, 1: cycles address, NREAD and write data are stable before PDS and VRAMCS fall; 1..7.
- HOLD_CYC, 1: cycles address and NREAD stay stable after PDS and VRAMCS rise; 1..7.

Ports:
- clk_main  in  1  main clock, 24 MHz
- nRES  in  1  asynchronous active-low reset
- req  in  1  request; sampled only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  {addr16, addr15..addr1}
- req_uds  in  1  upper-byte select (active high)
- req_rmrd  in  1  ROM-read mode level, passed to RMRD
- req_wdata  in  8  write byte
- done  out  1  one-cycle pulse at end of access
- err  out  1  one-cycle pulse, coincident with done, on timeout
- rdata  out  8  captured read byte; valid when done=1 and req_wr=0
- busy  out  1  high from request acceptance until done
- contention  out  1  sticky: both DBDIR inputs were high at capture
- VRAMCS  out  1  active-low chip select
- PDS  out  1  active-low data strobe
- NREAD  out  1  0 = read, 1 = write
- nUDS  out  1  active-low upper data strobe, equal to ~req_uds
- m68k_addr_16  out  1  address bit 16
- AB  out  15  address bits 15..1
- DB_IN  out  8  write data toward the planes block
- RMRD  out  1  ROM-read select
- VDTAC  in  1  active-low acknowledge
- DB_OUT_k052109  in  8  k052109 read data
- DBDIR_k052109  in  1  1 = k052109 drives the bus
- DB_OUT_k051962  in  8  k051962 read data
- DBDIR_k051962  in  1  1 = k051962 drives the bus

Behaviour:
- Reset values (nRES low, asynchronous):
  - state = IDLE
  - VRAMCS = 1, PDS = 1, NREAD = 1, nUDS = 1
  - AB = 0, m68k_addr_16 = 0, DB_IN = 0, RMRD = 0
  - done = 0, err = 0, busy = 0, rdata = 8'hFF, contention = 0
  - counters = 0
- VDTAC is registered through two flops (vdtac_s) before use; reset value 1.
- States: IDLE, SETUP, STROBE, WAIT, CAPTURE, RELEASE, HOLD.
- IDLE:
  - On req=1, latch all req_* fields into the bus outputs, set busy=1, load counter = SETUP_CYC, go to SETUP.
  - When req_wr=0, DB_IN holds its previous value.
- SETUP: count down; at 0, drive PDS=0 and VRAMCS=0, go to STROBE.
- STROBE: one cycle; guarantees at least 2 cycles of strobe before acknowledge is honoured. Load timeout counter = TIMEOUT, go to WAIT.
- WAIT:
  - If vdtac_s=0, go to CAPTURE.
  - Else decrement the counter. At 0, set the error flag and go to RELEASE without capturing; rdata keeps its old value.
- CAPTURE (one cycle), read data selection:
  - DBDIR_k052109=1: rdata = DB_OUT_k052109.
  - Else DBDIR_k051962=1: rdata = DB_OUT_k051962.
  - Else rdata = 8'hFF (open bus).
  - Both DBDIR high: k052109 wins, and contention is set.
  - On writes, rdata is unchanged.
- RELEASE:
  - Drive PDS=1 and VRAMCS=1 and load counter = HOLD_CYC.
  - Wait until vdtac_s=1, with the same TIMEOUT bound; a release timeout also sets err.
  - Then go to HOLD.
- HOLD:
  - Count down. At 0, pulse done (plus err if flagged), clear busy, set NREAD=1 and nUDS=1, go to IDLE.
  - AB, m68k_addr_16 and RMRD stay at their last values.
- Requests:
  - req is ignored while busy.
  - If req is still high in the IDLE cycle after done, a new access starts (back-to-back allowed; minimum 1 idle cycle between accesses).
- Latency: a read acknowledged after N WAIT cycles completes SETUP_CYC + 1 + N + 1 + release + HOLD_CYC cycles after acceptance.
- Reset mid-access: strobes return to inactive immediately and asynchronously; no done pulse.
- A VDTAC glitch high during CAPTURE is ignored; the captured value comes from the CAPTURE cycle.

Decomposition:
- Shared package planes_bus_pkg:
  - state enum
  - DTACK synchronizer depth (2)
  - OPEN_BUS = 8'hFF
- Natural sub-module: planes_dtack_sync (2-flop synchronizer, preset to 1 on nRES).
- Everything else is a single FSM.

Test Plan:
- Read, k052109 only: req_addr=16'h0C00, VDTAC falls 3 cycles after PDS, DBDIR_k052109=1, DB_OUT_k052109=8'h5A. Required: done=1, rdata=8'h5A, err=0, PDS low for at least 2 cycles.
- Write: req_wr=1, req_wdata=8'hA5, req_uds=1. Required: DB_IN=8'hA5 and NREAD=1 before PDS falls; nUDS=0 throughout; done once.
- Timeout: TIMEOUT=8, VDTAC held high. Required: done and err pulse together; PDS and VRAMCS back to 1; rdata unchanged (8'hFF after reset).
- Contention: both DBDIR=1, k052109 drives 8'h11, k051962 drives 8'h22. Required: rdata=8'h11, contention=1 and stays set.
- Back-to-back with req held high for 2 accesses. Required: exactly 2 done pulses; VRAMCS high for at least HOLD_CYC+1 cycles between accesses; no request accepted while busy.
- Reset mid-WAIT: nRES low while PDS=0. Required: PDS=1, VRAMCS=1, busy=0 immediately; no done pulse.
